// File: rtl/traffic_pkg.sv
// Shared state encoding and default phase durations for the intersection controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    AR_A = 3'd0,
    NS_G = 3'd1,
    NS_Y = 3'd2,
    AR_B = 3'd3,
    EW_G = 3'd4,
    EW_Y = 3'd5,
    WALK = 3'd6
  } state_t;

  localparam int DEF_T_GREEN     = 30;
  localparam int DEF_T_MIN_GREEN = 10;
  localparam int DEF_T_YELLOW    = 5;
  localparam int DEF_T_ALLRED    = 2;
  localparam int DEF_T_WALK      = 10;
  localparam int TIMER_W         = 8;

endpackage

// File: rtl/phase_timer.sv
// In-state cycle counter: restarts from zero on clear, flags the final cycle of a phase.
module phase_timer
  import traffic_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [TIMER_W-1:0] length,
  output logic [TIMER_W-1:0] count,
  output logic               done
);

  logic [TIMER_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;
  assign done  = (count_reg == length - 1'b1);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-way intersection controller with pedestrian walk phase and early green
// termination once the minimum green has been served.
module intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int T_GREEN     = DEF_T_GREEN,
  parameter int T_MIN_GREEN = DEF_T_MIN_GREEN,
  parameter int T_YELLOW    = DEF_T_YELLOW,
  parameter int T_ALLRED    = DEF_T_ALLRED,
  parameter int T_WALK      = DEF_T_WALK
) (
  input  logic clk,
  input  logic rst,
  input  logic ped_req,
  output logic ns_red,
  output logic ns_yellow,
  output logic ns_green,
  output logic ew_red,
  output logic ew_yellow,
  output logic ew_green,
  output logic walk,
  output logic ped_ack
);

  localparam logic [TIMER_W-1:0] LEN_GREEN  = TIMER_W'(T_GREEN);
  localparam logic [TIMER_W-1:0] LEN_YELLOW = TIMER_W'(T_YELLOW);
  localparam logic [TIMER_W-1:0] LEN_ALLRED = TIMER_W'(T_ALLRED);
  localparam logic [TIMER_W-1:0] LEN_WALK   = TIMER_W'(T_WALK);
  localparam logic [TIMER_W-1:0] MIN_LAST   = TIMER_W'(T_MIN_GREEN - 1);

  state_t             state_reg, state_next;
  logic               ped_pending_reg, ped_pending_next;
  logic [TIMER_W-1:0] phase_len;
  logic [TIMER_W-1:0] count;
  logic               done;
  logic               timer_clear;
  logic               want_walk;
  logic               min_green_met;

  // A request arriving this cycle counts immediately; WALK ignores the button.
  assign want_walk     = ped_pending_reg | (ped_req & (state_reg != WALK));
  assign min_green_met = (count >= MIN_LAST);
  assign timer_clear   = (state_next != state_reg);

  phase_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .length (phase_len),
    .count  (count),
    .done   (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= AR_A;
      ped_pending_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ped_pending_reg <= ped_pending_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    phase_len  = LEN_ALLRED;
    ns_red     = 1'b1;
    ns_yellow  = 1'b0;
    ns_green   = 1'b0;
    ew_red     = 1'b1;
    ew_yellow  = 1'b0;
    ew_green   = 1'b0;
    walk       = 1'b0;
    ped_ack    = 1'b0;
    case (state_reg)
      AR_A: begin
        phase_len = LEN_ALLRED;
        if (done) state_next = want_walk ? WALK : NS_G;
      end
      NS_G: begin
        phase_len = LEN_GREEN;
        ns_red    = 1'b0;
        ns_green  = 1'b1;
        if (done || (want_walk && min_green_met)) state_next = NS_Y;
      end
      NS_Y: begin
        phase_len = LEN_YELLOW;
        ns_red    = 1'b0;
        ns_yellow = 1'b1;
        if (done) state_next = AR_B;
      end
      AR_B: begin
        phase_len = LEN_ALLRED;
        if (done) state_next = EW_G;
      end
      EW_G: begin
        phase_len = LEN_GREEN;
        ew_red    = 1'b0;
        ew_green  = 1'b1;
        if (done || (want_walk && min_green_met)) state_next = EW_Y;
      end
      EW_Y: begin
        phase_len = LEN_YELLOW;
        ew_red    = 1'b0;
        ew_yellow = 1'b1;
        if (done) state_next = AR_A;
      end
      WALK: begin
        phase_len = LEN_WALK;
        walk      = 1'b1;
        ped_ack   = (count == '0);
        if (done) state_next = NS_G;
      end
      default: state_next = AR_A;
    endcase
    // Entering WALK serves every request outstanding, including one this cycle.
    ped_pending_next = (state_next == WALK) ? 1'b0 : want_walk;
  end

endmodule

// File: tb/tb_intersection_ctrl.sv
// Randomized scoreboard bench: a phase-timeline model predicts every output cycle.
module tb_intersection_ctrl;

  localparam int TG = 30, TMG = 10, TY = 5, TAR = 2, TW = 10;
  localparam int P_ARA = 0, P_NSG = 1, P_NSY = 2, P_ARB = 3, P_EWG = 4, P_EWY = 5, P_WALK = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ped_req = 1'b0;
  logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_ack;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  // Model: which phase we are in, how many cycles of it have been served, outstanding request.
  int m_ph = P_ARA;
  int m_served = 0;
  bit m_pend = 1'b0;
  int succ[7] = '{P_NSG, P_NSY, P_ARB, P_EWG, P_EWY, P_ARA, P_NSG};

  intersection_ctrl #(
    .T_GREEN(TG), .T_MIN_GREEN(TMG), .T_YELLOW(TY), .T_ALLRED(TAR), .T_WALK(TW)
  ) dut (
    .clk(clk), .rst(rst), .ped_req(ped_req),
    .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
    .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
    .walk(walk), .ped_ack(ped_ack)
  );

  always #5 clk = ~clk;

  function automatic int dur(int ph);
    case (ph)
      P_NSG, P_EWG: return TG;
      P_NSY, P_EWY: return TY;
      P_WALK:       return TW;
      default:      return TAR;
    endcase
  endfunction

  function automatic logic [7:0] lamps(int ph, int served);
    logic [2:0] ns, ew;
    ns = (ph == P_NSG) ? 3'b001 : (ph == P_NSY) ? 3'b010 : 3'b100;
    ew = (ph == P_EWG) ? 3'b001 : (ph == P_EWY) ? 3'b010 : 3'b100;
    return {ns, ew, ph == P_WALK, (ph == P_WALK) && (served == 0)};
  endfunction

  task automatic model_step(bit r, bit q);
    bit want, finished;
    int nxt;
    if (r) begin
      m_ph = P_ARA; m_served = 0; m_pend = 1'b0;
    end else begin
      want = m_pend || (q && m_ph != P_WALK);
      finished = (m_served + 1 == dur(m_ph)) ||
                 ((m_ph == P_NSG || m_ph == P_EWG) && want && m_served + 1 >= TMG);
      if (finished) begin
        nxt = (m_ph == P_ARA && want) ? P_WALK : succ[m_ph];
        m_ph = nxt;
        m_served = 0;
        m_pend = (nxt == P_WALK) ? 1'b0 : want;
      end else begin
        m_served++;
        m_pend = want;
      end
    end
  endtask

  task automatic drive(bit r, bit q);
    @(negedge clk);
    rst = r;
    ped_req = q;
    model_step(r, q);
    exp_q.push_back(lamps(m_ph, m_served));
  endtask

  // Monitor: one expected vector per clock edge, compared just after the edge.
  initial begin
    logic [7:0] e, got;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_ack};
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL lamps cycle=%0d got=%b want=%b", cyc, got, e);
        end
        total++;
        assert ($onehot({ns_red, ns_yellow, ns_green}) && $onehot({ew_red, ew_yellow, ew_green})
                && (ns_red || ew_red))
        else begin
          bad++;
          $display("FAIL lamp_safety cycle=%0d ns=%b ew=%b", cyc,
                   {ns_red, ns_yellow, ns_green}, {ew_red, ew_yellow, ew_green});
        end
      end
    end
  end

  initial begin
    int guard;
    repeat (8) drive(1'b1, 1'b0);
    repeat (160) drive(1'b0, 1'b0);
    repeat (1200) drive(1'b0, $urandom_range(0, 39) == 0);
    repeat (200) drive(1'b0, 1'b1);
    repeat (100) drive(1'b0, 1'b0);

    // Reset in the fourth WALK cycle must abort straight to AR_A with nothing pending.
    guard = 0;
    while (!(m_ph == P_WALK && m_served == 3) && guard < 300) begin
      drive(1'b0, 1'b1);
      guard++;
    end
    total++;
    if (guard >= 300) begin
      bad++;
      $display("FAIL reach_walk cycles=%0d limit=300", guard);
    end
    drive(1'b1, 1'b0);
    repeat (120) drive(1'b0, 1'b0);

    // Reset mid-green.
    guard = 0;
    while (!(m_ph == P_EWG && m_served == 15) && guard < 300) begin
      drive(1'b0, 1'b0);
      guard++;
    end
    drive(1'b1, 1'b0);
    repeat (80) drive(1'b0, 1'b0);

    repeat (1000) drive($urandom_range(0, 149) == 0, $urandom_range(0, 19) == 0);
    repeat (80) drive(1'b0, 1'b0);

    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(posedge clk);
      #2;
      guard++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/intersection_ctrl.md
INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 Parameter T_GREEN, default 30, sets the green phase length in clk cycles (1 cycle = 1 s).
REQ-002 Parameter T_MIN_GREEN, default 10, sets the minimum green length before a pedestrian request may cut green short.
REQ-003 Parameter T_YELLOW, default 5, sets the yellow phase length in cycles.
REQ-004 Parameter T_ALLRED, default 2, sets the all-red clearance length in cycles.
REQ-005 Parameter T_WALK, default 10, sets the pedestrian walk phase length in cycles.
REQ-006 Port clk, input, 1, is the single system clock; all state changes occur on its rising edge.
REQ-007 Port rst, input, 1, is the synchronous active-high reset.
REQ-008 Port ped_req, input, 1, is the pedestrian button, sampled every cycle, of any pulse length.
REQ-009 Ports ns_red, ns_yellow, ns_green, output, 1 each, drive the north-south lamps.
REQ-010 Ports ew_red, ew_yellow, ew_green, output, 1 each, drive the east-west lamps.
REQ-011 Port walk, output, 1, is high only during the WALK state.
REQ-012 Port ped_ack, output, 1, is a one-cycle pulse in the first WALK cycle.

Function
REQ-013 The FSM SHALL have states AR_A, NS_G, NS_Y, AR_B, EW_G, EW_Y and WALK.
REQ-014 Nominal order SHALL be AR_A -> NS_G -> NS_Y -> AR_B -> EW_G -> EW_Y -> AR_A.
REQ-015 Each state SHALL last exactly its parameter length in cycles (AR_A/AR_B: T_ALLRED; NS_G/EW_G: T_GREEN; NS_Y/EW_Y: T_YELLOW; WALK: T_WALK), measured by an 8-bit in-state counter that clears on every transition.
REQ-016 Outputs SHALL be Moore-decoded from the state register: exactly one lamp per direction lit; both directions red in AR_A, AR_B and WALK; never both directions non-red.
REQ-017 An internal ped_pending flag SHALL be set by ped_req=1 in any state except WALK and cleared on entry to WALK.
REQ-018 If ped_pending is set when AR_A completes, AR_A SHALL go to WALK instead of NS_G, and WALK SHALL go to NS_G.
REQ-019 In NS_G or EW_G with ped_pending set and at least T_MIN_GREEN cycles elapsed, the green SHALL end at the next cycle boundary and advance to the yellow state.
REQ-020 If ped_req is high in the cycle AR_A transitions to WALK, it SHALL be absorbed by that walk, not left pending.
REQ-021 ped_req during WALK SHALL be ignored.
REQ-022 With no pedestrian traffic the full cycle SHALL be 74 cycles (2+30+5+2+30+5).

Reset
REQ-023 On rst=1 at a clock edge, the FSM SHALL enter AR_A with the counter at 0 and ped_pending cleared.
REQ-024 While in reset, all red outputs SHALL be 1; yellow, green, walk and ped_ack SHALL be 0.
REQ-025 Reset asserted mid-phase, including mid-WALK or mid-green, SHALL abort the phase immediately to AR_A with no yellow.
REQ-026 After rst is released, the first NS_G cycle SHALL come T_ALLRED cycles later.

Structure
REQ-027 Package traffic_pkg SHALL hold the state enumeration and the default duration constants.
REQ-028 The in-state counter SHALL be the sub-module phase_timer (inputs clear and the length; output done when the count reaches length-1).
REQ-029 The implementation SHALL contain no combinational path from ped_req to any output.

Verification
REQ-030 Hold rst high for 8 cycles, then release -> all-red during reset; ns_green rises exactly 2 cycles after release; outputs then repeat with a 74-cycle period.
REQ-031 Pulse ped_req for 1 cycle at NS_G cycle 3 -> green ends after 10 cycles, then 5 yellow; the route runs AR_B, EW_G (which is also cut at 10 cycles), EW_Y, AR_A, then WALK for 10 cycles with ped_ack on its first cycle.
REQ-032 Pulse ped_req at EW_G cycle 20 -> EW_G ends after that cycle, then EW_Y 5, AR_A 2, WALK 10, NS_G.
REQ-033 Hold ped_req high continuously for 200 cycles -> every AR_A goes to WALK, greens last exactly 10 cycles, and no request persists past WALK entry.
REQ-034 Assert rst for 1 cycle in WALK cycle 4 -> next cycle is AR_A with walk=0 and ped_pending=0.
REQ-035 Throughout all scenarios, an assertion shall check that the ns and ew directions are never both non-red and that each direction always has exactly one lamp lit.
